bcd_decimal_scan: RTL and testbench

BCD_DECIMAL_SCAN -- requirements
Module: bcd_decimal_scan

---
 rtl/bcd_decimal_scan.sv | 111 +++++++++++
 tb/tb_bcd_decimal_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_decimal_scan.sv
// Streams the BCD digits of a captured word one per beat, least significant first,
// as one-hot decimal codes with per-digit and per-word error flags.
module bcd_decimal_scan #(
  parameter int DIGITS     = 4,
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit MSB_ZERO   = 1'b1,
  localparam int IDXW      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   BCD,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9:0]            decimal,
  output logic [IDXW-1:0]       digit_idx,
  output logic                  out_last,
  output logic                  error,
  output logic                  word_err
);

  localparam logic [9:0]      INACTIVE = {10{ACTIVE_LOW}};
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] word;
  logic                acc;        // OR of error over the beats already consumed
  logic [IDXW-1:0]     nxt_idx;
  logic [3:0]          nxt_digit;
  logic                nxt_err;
  logic                first_err;

  function automatic logic [9:0] decode(input logic [3:0] d);
    logic [9:0] hot;
    hot = '0;
    if (d <= 4'd9)
      hot = 10'b1 << (MSB_ZERO ? (4'd9 - d) : d);
    return hot ^ INACTIVE;
  endfunction

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    nxt_idx   = digit_idx + IDXW'(1);
    nxt_digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (nxt_idx == IDXW'(i))
        nxt_digit = word[4*i +: 4];
    nxt_err   = (nxt_digit > 4'd9);
    first_err = (BCD[3:0] > 4'd9);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      digit_idx <= '0;
      decimal   <= INACTIVE;
      error     <= 1'b0;
      word_err  <= 1'b0;
      out_last  <= 1'b0;
      acc       <= 1'b0;
      word      <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            word      <= BCD;
            state     <= SCAN;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            digit_idx <= '0;
            acc       <= 1'b0;
            decimal   <= decode(BCD[3:0]);
            error     <= first_err;
            out_last  <= (DIGITS == 1);
            word_err  <= (DIGITS == 1) && first_err;
          end
        end
        SCAN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              digit_idx <= '0;
              decimal   <= INACTIVE;
              error     <= 1'b0;
              word_err  <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              digit_idx <= nxt_idx;
              acc       <= acc | error;
              decimal   <= decode(nxt_digit);
              error     <= nxt_err;
              out_last  <= (nxt_idx == LAST_IDX);
              word_err  <= (nxt_idx == LAST_IDX) && (acc | error | nxt_err);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_decimal_scan.sv
// Scoreboard bench: stimulus pushes expected beats, negedge monitors pop and compare on handshakes.
module tb_bcd_decimal_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, error, word_err;
  logic [15:0] bcd;
  logic [9:0] decimal;
  logic [1:0] digit_idx;

  logic       in_valid2, in_ready2, out_valid2, out_ready2, out_last2, error2, word_err2;
  logic [3:0] bcd2;
  logic [9:0] decimal2;
  logic [0:0] digit_idx2;

  typedef struct packed {
    logic [9:0] dec;
    logic [3:0] idx;
    logic       last;
    logic       err;
    logic       werr;
  } beat_t;

  beat_t exp_q[$];
  beat_t exp2_q[$];
  beat_t got, got2;
  int checks = 0;
  int errors = 0;

  bcd_decimal_scan dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .BCD(bcd),
    .out_valid(out_valid), .out_ready(out_ready), .decimal(decimal),
    .digit_idx(digit_idx), .out_last(out_last), .error(error), .word_err(word_err)
  );

  bcd_decimal_scan #(.DIGITS(1), .ACTIVE_LOW(1'b1), .MSB_ZERO(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .BCD(bcd2),
    .out_valid(out_valid2), .out_ready(out_ready2), .decimal(decimal2),
    .digit_idx(digit_idx2), .out_last(out_last2), .error(error2), .word_err(word_err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [9:0] dec, input logic [3:0] idx,
                      input logic last, input logic err, input logic werr);
    exp_q.push_back({dec, idx, last, err, werr});
  endtask

  task automatic push2(input logic [9:0] dec, input logic err);
    exp2_q.push_back({dec, 4'd0, 1'b1, err, err});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got = {decimal, 2'b00, digit_idx, out_last, error, word_err};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none at %0t", got, $time);
      end else begin
        check("beat", got, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      got2 = {decimal2, 3'b000, digit_idx2, out_last2, error2, word_err2};
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat2: got %0h expected none at %0t", got2, $time);
      end else begin
        check("beat2", got2, exp2_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      @(posedge clk); #1;
    end
    check("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1;
    bcd      = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (in_ready && !out_valid) break;
      @(posedge clk); #1;
    end
    check("idle_reached", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic send2(input logic [3:0] w);
    check("in_ready2_before_send", in_ready2, 1);
    in_valid2 = 1'b1;
    bcd2      = w;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    @(posedge clk); #1;
    check("t_dut2_throughput", {in_ready2, out_valid2}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; bcd = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; bcd2 = '0; out_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_handshake", {in_ready, out_valid}, 2'b00);
    check("rst_outputs", {decimal, digit_idx, out_last, error, word_err}, '0);
    check("rst_dut2", {in_ready2, out_valid2, decimal2, out_last2, error2, word_err2},
          {2'b00, 10'h3FF, 3'b000});
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", {in_ready, in_ready2}, 2'b11);

    // Basic decode, four back-to-back beats
    push(10'b1000000000, 4'd0, 1'b0, 1'b0, 1'b0);
    push(10'b0100000000, 4'd1, 1'b0, 1'b0, 1'b0);
    push(10'b0001000000, 4'd2, 1'b0, 1'b0, 1'b0);
    push(10'b0000000001, 4'd3, 1'b1, 1'b0, 1'b0);
    send_word(16'h9310);
    repeat (4) @(posedge clk);
    #1;
    check("t1_idle_after_4", {in_ready, out_valid}, 2'b10);

    // Invalid code mid-word; word_err reported on the clean last beat
    push(10'b0000010000, 4'd0, 1'b0, 1'b0, 1'b0);
    push(10'b0000000000, 4'd1, 1'b0, 1'b1, 1'b0);
    push(10'b1000000000, 4'd2, 1'b0, 1'b0, 1'b0);
    push(10'b1000000000, 4'd3, 1'b1, 1'b0, 1'b1);
    send_word(16'h00A5);
    repeat (4) @(posedge clk);
    #1;
    check("t2_idle_after_4", {in_ready, out_valid}, 2'b10);

    // Backpressure while idx1 is shown
    push(10'b0100000000, 4'd0, 1'b0, 1'b0, 1'b0);
    push(10'b0010000000, 4'd1, 1'b0, 1'b0, 1'b0);
    push(10'b0000000100, 4'd2, 1'b0, 1'b0, 1'b0);
    push(10'b0000100000, 4'd3, 1'b1, 1'b0, 1'b0);
    send_word(16'h4721);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t3_hold", {out_valid, decimal, digit_idx, out_last, error, word_err},
            {1'b1, 10'b0010000000, 2'd1, 3'b000});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_idx2_after_release", {digit_idx, decimal}, {2'd2, 10'b0000000100});
    wait_idle();

    // Reset right after the idx1 handshake discards the word
    push(10'b0000010000, 4'd0, 1'b0, 1'b0, 1'b0);
    push(10'b0000001000, 4'd1, 1'b0, 1'b0, 1'b0);
    send_word(16'h8765);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("t4_rst_kills_beat", {out_valid, in_ready}, 2'b00);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_ready_after_rst", {in_ready, out_valid}, 2'b10);
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_more_beats", {out_valid, digit_idx}, 3'b000);

    // in_valid held through SCAN with BCD churning; only the IDLE cycle accepts
    push(10'b0000100000, 4'd0, 1'b0, 1'b0, 1'b0);
    push(10'b0001000000, 4'd1, 1'b0, 1'b0, 1'b0);
    push(10'b0010000000, 4'd2, 1'b0, 1'b0, 1'b0);
    push(10'b0100000000, 4'd3, 1'b1, 1'b0, 1'b0);
    push(10'b0000000010, 4'd0, 1'b0, 1'b0, 1'b0);
    push(10'b0000000100, 4'd1, 1'b0, 1'b0, 1'b0);
    push(10'b0000001000, 4'd2, 1'b0, 1'b0, 1'b0);
    push(10'b0000010000, 4'd3, 1'b1, 1'b0, 1'b0);
    check("t5_ready", in_ready, 1);
    in_valid = 1'b1;
    bcd      = 16'h1234;
    @(posedge clk); #1;
    bcd = 16'hFFFF; @(posedge clk); #1;
    bcd = 16'h0000; @(posedge clk); #1;
    bcd = 16'hAAAA; @(posedge clk); #1;
    bcd = 16'h8888; @(posedge clk); #1;
    check("t5_idle_gap", {in_ready, out_valid}, 2'b10);
    bcd = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t5_second_accept", {in_ready, out_valid, digit_idx}, {2'b01, 2'd0});
    wait_idle();

    // Invalid code on the last digit
    push(10'b1000000000, 4'd0, 1'b0, 1'b0, 1'b0);
    push(10'b1000000000, 4'd1, 1'b0, 1'b0, 1'b0);
    push(10'b1000000000, 4'd2, 1'b0, 1'b0, 1'b0);
    push(10'b0000000000, 4'd3, 1'b1, 1'b1, 1'b1);
    send_word(16'hB000);
    wait_idle();

    // Single-digit, active-low, direct-index instance
    push2(10'b1111111011, 1'b0);
    send2(4'h2);
    push2(10'b1111111111, 1'b1);
    send2(4'hF);
    push2(10'b0111111111, 1'b0);
    send2(4'h9);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("queue2_drained", exp2_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
